// File: rtl/mc_cpu_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mc_cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  typedef enum logic [1:0] {
    TRAP_NONE        = 2'b00,
    TRAP_ILLEGAL     = 2'b01,
    TRAP_MEM_TIMEOUT = 2'b10
  } trap_cause_t;

  // Every select and strobe the controller drives into the datapath
  typedef struct packed {
    logic       mem_req;
    logic       i_or_d;
    logic       alu_src_a;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       ext_zero;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_ctl_t   alu_control;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       branch_ne;
    logic       retire;
    logic       halted;
  } ctl_t;

  // States that own the memory bus and therefore wait on mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // Opcodes that only decode when the extended ISA is enabled
  function automatic logic is_ext_op(input logic [5:0] op);
    return (op == OP_BNE) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU operation; flags any funct the datapath cannot execute.
module mc_alu_decoder
  import mc_cpu_pkg::*;
(
  input  logic [5:0] funct,
  output alu_ctl_t   alu_control,
  output logic       illegal
);

  // Pure lookup; unknown functs fall back to add so the ALU input stays defined
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: handshaked memory states with a watchdog,
// optional bne/andi/ori decode, and a sticky trap/halt state.
module mc_control_fsm
  import mc_cpu_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 16,
  parameter int EXT_ISA       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       ext_zero,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       retire,
  output logic       halted,
  output logic [1:0] trap_cause
);

  localparam int             CW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  trap_cause_t   trap_q;

  logic          rdy;
  logic          wait_last;
  state_t        dec_next;
  alu_ctl_t      fn_alu;
  logic          fn_illegal;
  ctl_t          ctl;

  // Without the handshake every memory access is treated as completing at once
  assign rdy       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign wait_last = (wait_cnt == WAIT_LAST);

  mc_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (fn_alu),
    .illegal     (fn_illegal)
  );

  // Opcode dispatch out of DECODE; extension opcodes trap when EXT_ISA is off
  always_comb begin
    dec_next = S_TRAP;
    case (opcode)
      OP_RTYPE:     dec_next = S_EXEC;
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_BEQ:       dec_next = S_BRANCH;
      OP_ADDI:      dec_next = S_IEXEC;
      OP_J:         dec_next = S_JUMP;
      OP_BNE:       dec_next = (EXT_ISA != 0) ? S_BRANCH : S_TRAP;
      OP_ANDI,
      OP_ORI:       dec_next = (EXT_ISA != 0) ? S_IEXEC : S_TRAP;
      default:      dec_next = S_TRAP;
    endcase
  end

  // State, wait counter and trap cause; reset aborts any instruction to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      trap_q   <= TRAP_NONE;
    end else begin
      // Non-memory states keep the counter at zero so every memory state is entered fresh
      if (!is_mem_state(state)) wait_cnt <= '0;
      case (state)
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          if (rdy) begin
            wait_cnt <= '0;
            state    <= (state == S_FETCH)   ? S_DECODE :
                        (state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
          end else if (wait_last) begin
            state  <= S_TRAP;
            trap_q <= TRAP_MEM_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          state <= dec_next;
          if (dec_next == S_TRAP) trap_q <= TRAP_ILLEGAL;
        end
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_EXEC: begin
          if (fn_illegal) begin
            state  <= S_TRAP;
            trap_q <= TRAP_ILLEGAL;
          end else begin
            state <= S_ALUWB;
          end
        end
        S_IEXEC:  state <= S_IWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP: state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the datapath controls; memory strobes also qualify on ready
  always_comb begin
    ctl             = '0;
    ctl.alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = rdy;
        ctl.pc_write  = rdy;
      end
      S_DECODE: ctl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        ctl.i_or_d  = 1'b1;
        ctl.mem_req = 1'b1;
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.retire     = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_req   = 1'b1;
        ctl.mem_write = rdy;
        ctl.retire    = rdy;
      end
      S_EXEC: begin
        ctl.alu_src_a   = 1'b1;
        ctl.alu_control = fn_alu;
      end
      S_ALUWB: begin
        ctl.reg_dest  = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a   = 1'b1;
        ctl.alu_control = ALU_SUB;
        ctl.pc_src      = 2'b01;
        ctl.branch      = (opcode == OP_BEQ);
        ctl.branch_ne   = (opcode == OP_BNE);
        ctl.retire      = 1'b1;
      end
      S_IEXEC: begin
        ctl.alu_src_a   = 1'b1;
        ctl.alu_src_b   = 2'b10;
        ctl.ext_zero    = is_ext_op(opcode) && (opcode != OP_BNE);
        ctl.alu_control = (opcode == OP_ANDI) ? ALU_AND :
                          (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      S_IWB: begin
        ctl.reg_write = 1'b1;
        ctl.retire    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_src   = 2'b10;
        ctl.pc_write = 1'b1;
        ctl.retire   = 1'b1;
      end
      S_TRAP:  ctl.halted = 1'b1;
      default: ctl.halted = 1'b0;
    endcase
    // Nothing may write architectural state while reset is held
    if (reset) begin
      ctl.mem_req   = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.pc_write  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.reg_write = 1'b0;
      ctl.branch    = 1'b0;
      ctl.branch_ne = 1'b0;
      ctl.retire    = 1'b0;
    end
  end

  assign mem_req     = ctl.mem_req;
  assign i_or_d      = ctl.i_or_d;
  assign alu_src_a   = ctl.alu_src_a;
  assign reg_dest    = ctl.reg_dest;
  assign mem_to_reg  = ctl.mem_to_reg;
  assign ext_zero    = ctl.ext_zero;
  assign alu_src_b   = ctl.alu_src_b;
  assign pc_src      = ctl.pc_src;
  assign alu_control = ctl.alu_control;
  assign ir_write    = ctl.ir_write;
  assign pc_write    = ctl.pc_write;
  assign mem_write   = ctl.mem_write;
  assign reg_write   = ctl.reg_write;
  assign branch      = ctl.branch;
  assign branch_ne   = ctl.branch_ne;
  assign retire      = ctl.retire;
  assign halted      = ctl.halted;
  assign trap_cause  = trap_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm. Three configurations run side by side:
// handshake with timeout 4 and extended ISA, no handshake with base ISA, and
// handshake with timeout 1 and base ISA. Each instruction is expanded into its
// per-cycle phase sequence; expected control words go into a queue that a
// monitor drains and compares every cycle.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req, i_or_d, alu_src_a, reg_dest, mem_to_reg, ext_zero;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       ir_write, pc_write, mem_write, reg_write, branch, branch_ne, retire, halted;
    logic [1:0] trap_cause;
  } cw_t;

  typedef struct {
    cw_t        cw;
    int         ph;
    logic [5:0] op;
  } exp_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_IEXEC = 9,
                 P_IWB = 10, P_JUMP = 11, P_TRAP = 12;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                         T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000,
                         T_ANDI = 6'b001100, T_ORI = 6'b001101, T_J = 6'b000010;

  localparam int NLANE  = 3;
  localparam int N_INSN = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  function automatic string ph_name(input int ph);
    case (ph)
      P_FETCH:    return "fetch";
      P_DECODE:   return "decode";
      P_MEMADR:   return "memadr";
      P_MEMREAD:  return "memread";
      P_MEMWB:    return "memwb";
      P_MEMWRITE: return "memwrite";
      P_EXEC:     return "exec";
      P_ALUWB:    return "aluwb";
      P_BRANCH:   return "branch";
      P_IEXEC:    return "iexec";
      P_IWB:      return "iwb";
      P_JUMP:     return "jump";
      default:    return "trap";
    endcase
  endfunction

  // ALU code for an R-type funct; ok=0 for functs the CPU does not implement
  function automatic logic [2:0] r_alu(input logic [5:0] fn, output bit ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b010; end
    endcase
  endfunction

  function automatic logic [5:0] legal_fn(input int i);
    case (i)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      default: return 6'b101010;
    endcase
  endfunction

  // Control word the datapath should see in a given phase of an instruction
  function automatic cw_t word(input int ph, input logic rdy, input logic rst,
                               input logic [5:0] op, input logic [5:0] fn, input logic [1:0] cause);
    cw_t w = '0;
    bit  ok;
    w.alu_control = 3'b010;
    case (ph)
      P_FETCH:    begin w.mem_req = 1; w.alu_src_b = 2'b01; w.ir_write = rdy; w.pc_write = rdy; end
      P_DECODE:   w.alu_src_b = 2'b11;
      P_MEMADR:   begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
      P_MEMREAD:  begin w.i_or_d = 1; w.mem_req = 1; end
      P_MEMWB:    begin w.mem_to_reg = 1; w.reg_write = 1; w.retire = 1; end
      P_MEMWRITE: begin w.i_or_d = 1; w.mem_req = 1; w.mem_write = rdy; w.retire = rdy; end
      P_EXEC:     begin w.alu_src_a = 1; w.alu_control = r_alu(fn, ok); end
      P_ALUWB:    begin w.reg_dest = 1; w.reg_write = 1; w.retire = 1; end
      P_BRANCH: begin
        w.alu_src_a = 1; w.alu_control = 3'b110; w.pc_src = 2'b01; w.retire = 1;
        w.branch = (op == T_BEQ); w.branch_ne = (op == T_BNE);
      end
      P_IEXEC: begin
        w.alu_src_a = 1; w.alu_src_b = 2'b10;
        w.ext_zero = (op == T_ANDI) || (op == T_ORI);
        w.alu_control = (op == T_ANDI) ? 3'b000 : (op == T_ORI) ? 3'b001 : 3'b010;
      end
      P_IWB:      begin w.reg_write = 1; w.retire = 1; end
      P_JUMP:     begin w.pc_src = 2'b10; w.pc_write = 1; w.retire = 1; end
      default:    begin w.halted = 1; w.trap_cause = cause; end
    endcase
    if (rst) begin
      w.mem_req = 0; w.ir_write = 0; w.pc_write = 0; w.mem_write = 0;
      w.reg_write = 0; w.branch = 0; w.branch_ne = 0; w.retire = 0;
    end
    return w;
  endfunction

  for (genvar g = 0; g < NLANE; g++) begin : lane
    localparam int HS  = (g == 1) ? 0 : 1;
    localparam int TO  = (g == 0) ? 4 : (g == 1) ? 3 : 1;
    localparam int EXT = (g == 0) ? 1 : 0;

    logic       reset, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, i_or_d, alu_src_a, reg_dest, mem_to_reg, ext_zero;
    logic [1:0] alu_src_b, pc_src, trap_cause;
    logic [2:0] alu_control;
    logic       ir_write, pc_write, mem_write, reg_write, branch, branch_ne, retire, halted;

    exp_t       sbq[$];
    int         plist[$];
    int         n, abort_at;
    bit         stop;
    logic [5:0] cop, cfn;
    logic [1:0] cause;

    mc_control_fsm #(.MEM_HANDSHAKE(HS), .MEM_TIMEOUT(TO), .EXT_ISA(EXT)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .i_or_d(i_or_d), .alu_src_a(alu_src_a), .reg_dest(reg_dest),
      .mem_to_reg(mem_to_reg), .ext_zero(ext_zero), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .ir_write(ir_write), .pc_write(pc_write),
      .mem_write(mem_write), .reg_write(reg_write), .branch(branch), .branch_ne(branch_ne),
      .retire(retire), .halted(halted), .trap_cause(trap_cause)
    );

    // One clock of stimulus plus the control word expected during that clock
    task automatic cyc(input logic rst, input logic rdy, input int ph);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rst;
      mem_ready = rdy;
      opcode    = cop;
      funct     = cfn;
      e.ph = ph;
      e.op = cop;
      e.cw = word(ph, (HS != 0) ? rdy : 1'b1, rst, cop, cfn, cause);
      sbq.push_back(e);
    endtask

    // Normal phase cycle, or the reset that aborts this instruction
    task automatic emit(input int ph, input logic rdy);
      cyc((n == abort_at) ? 1'b1 : 1'b0, rdy, ph);
      if (n == abort_at) stop = 1;
      n++;
    endtask

    task automatic trap_seq();
      repeat (2) cyc(1'b0, 1'($urandom_range(0, 1)), P_TRAP);
      cyc(1'b1, 1'b0, P_TRAP);
      stop = 1;
    endtask

    // A memory phase: some cycles of not-ready, then ready or a watchdog trap
    task automatic mem_phase(input int ph);
      int r, lat, lows;
      if (HS == 0) begin
        emit(ph, 1'($urandom_range(0, 1)));
        return;
      end
      r    = $urandom_range(0, 9);
      lat  = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 3) : (TO - 1 + $urandom_range(0, 2));
      lows = (lat < TO) ? lat : TO;
      for (int w = 0; w < lows; w++) begin
        emit(ph, 1'b0);
        if (stop) return;
      end
      if (lat >= TO) begin
        cause = 2'b10;
        trap_seq();
      end else begin
        emit(ph, 1'b1);
      end
    endtask

    task automatic pick_and_plan();
      int r;
      bit ok;
      logic [2:0] unused_alu;
      r   = $urandom_range(0, 99);
      cfn = 6'($urandom_range(0, 63));
      if (r < 22)      begin cop = T_R; cfn = legal_fn($urandom_range(0, 4)); end
      else if (r < 27) cop = T_R;
      else if (r < 40) cop = T_LW;
      else if (r < 50) cop = T_SW;
      else if (r < 58) cop = T_BEQ;
      else if (r < 66) cop = T_BNE;
      else if (r < 72) cop = T_ADDI;
      else if (r < 78) cop = T_ANDI;
      else if (r < 84) cop = T_ORI;
      else if (r < 92) cop = T_J;
      else             cop = 6'($urandom_range(0, 63));
      cause = 2'b01;
      plist = '{P_FETCH, P_DECODE};
      case (cop)
        T_R: begin
          unused_alu = r_alu(cfn, ok);
          plist.push_back(P_EXEC);
          plist.push_back(ok ? P_ALUWB : P_TRAP);
        end
        T_LW:   begin plist.push_back(P_MEMADR); plist.push_back(P_MEMREAD); plist.push_back(P_MEMWB); end
        T_SW:   begin plist.push_back(P_MEMADR); plist.push_back(P_MEMWRITE); end
        T_BEQ:  plist.push_back(P_BRANCH);
        T_BNE:  plist.push_back((EXT != 0) ? P_BRANCH : P_TRAP);
        T_ADDI: begin plist.push_back(P_IEXEC); plist.push_back(P_IWB); end
        T_ANDI, T_ORI: begin
          if (EXT != 0) begin plist.push_back(P_IEXEC); plist.push_back(P_IWB); end
          else plist.push_back(P_TRAP);
        end
        T_J:    plist.push_back(P_JUMP);
        default: plist.push_back(P_TRAP);
      endcase
    endtask

    initial begin : drv
      reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
      cop = '0; cfn = '0; cause = 2'b00; n = 0; abort_at = -1; stop = 0;
      cyc(1'b1, 1'b0, P_FETCH);
      for (int k = 0; k < N_INSN; k++) begin
        pick_and_plan();
        n        = 0;
        stop     = 0;
        abort_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 5)) : -1;
        for (int i = 0; i < plist.size() && !stop; i++) begin
          if (plist[i] == P_TRAP)
            trap_seq();
          else if (plist[i] == P_FETCH || plist[i] == P_MEMREAD || plist[i] == P_MEMWRITE)
            mem_phase(plist[i]);
          else
            emit(plist[i], 1'($urandom_range(0, 1)));
        end
      end
      repeat (3) @(posedge clk);
      n_done++;
    end

    initial begin : mon
      exp_t e;
      cw_t  a;
      forever begin
        @(negedge clk);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          a = {mem_req, i_or_d, alu_src_a, reg_dest, mem_to_reg, ext_zero, alu_src_b, pc_src,
               alu_control, ir_write, pc_write, mem_write, reg_write, branch, branch_ne,
               retire, halted, trap_cause};
          n_cmp++;
          if (a !== e.cw) begin
            n_bad++;
            $display("FAIL lane%0d %s op=%b: actual=%h required=%h", g, ph_name(e.ph), e.op, a, e.cw);
          end
        end
      end
    end
  end

  initial begin : summary
    int t;
    t = 0;
    while (n_done < NLANE && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < NLANE) begin
      n_bad++;
      $display("FAIL watchdog: lanes finished=%0d required=%0d", n_done, NLANE);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
